pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised pipeline control unit for the 5-stage ARM core: it generates the freeze, flush and bubble controls that the stage registers currently receive as constant zeros. It tracks a shadow copy of the EXE and MEM stage destinations, detects read-after-write hazards for the instruction in ID (full-stall or load-use-only mode), kills wrong-path work on a taken branch, and honours an external memory stall. Saturating performance counters expose cycle, stall and flush counts. Sits beside IF_Stage_Reg / ID_Stage_Reg and is driven from ID-stage decode and the EXE-stage branch result.

## Interface
Parameters:
- REG_W, 4, register-index width (dest/src fields)
- FWD_EN, 0, 0 = stall on any EXE/MEM RAW match; 1 = forwarding present, stall only on load-use against EXE
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_src1, id_src2  in  REG_W  source register indices
- id_src1_en, id_src2_en  in  1  source actually read (src2_en = Two_src)
- id_wb_en  in  1  ID instruction writes a register
- id_mem_r_en  in  1  ID instruction is a load
- id_dest  in  REG_W  ID destination register
- branch_taken  in  1  EXE-stage branch resolved taken
- mem_stall  in  1  memory not ready; whole pipe holds
- hazard  out  1  raw data-hazard detect (comb)
- freeze  out  1  hold PC and IF/ID register (comb)
- flush  out  1  clear IF/ID register (comb)
- bubble  out  1  clear ID/EXE register (comb)
- id_issue  out  1  ID instruction advances this cycle (comb)
- cycle_cnt, stall_cnt, flush_cnt  out  CNT_W  registered counters

## Operation
- State: exe_valid, exe_wb_en, exe_mem_r, exe_dest; mem_valid, mem_wb_en, mem_dest. Reset: all 0.
- Match: m(s) = id_srcX_en & (id_srcX == s.dest), over X in {1,2}.
- FWD_EN=0: hazard = id_valid & ((exe_valid & exe_wb_en & m(exe)) | (mem_valid & mem_wb_en & m(mem))).
- FWD_EN=1: hazard = id_valid & exe_valid & exe_mem_r & m(exe); MEM stage never stalls.
- Register index 0 is an ordinary register; no exclusion.
- Priority mem_stall > branch_taken > hazard:
  - mem_stall=1: freeze=1, flush=0, bubble=0, id_issue=0; shadow state holds; branch flush deferred until mem_stall falls.
  - else branch_taken=1: flush=1, bubble=1, freeze=0, id_issue=0.
  - else hazard=1: freeze=1, bubble=1, flush=0, id_issue=0.
  - else: freeze=flush=bubble=0, id_issue=id_valid.
- Shadow update when mem_stall=0: EXE <= id_issue ? {1, id_wb_en, id_mem_r_en, id_dest} : {0,0,0,0}; MEM <= {exe_valid, exe_wb_en, exe_dest}.
- Counters (saturate at all-ones, never wrap): cycle_cnt +1 every cycle out of reset; stall_cnt +1 when hazard & !branch_taken & !mem_stall; flush_cnt +1 when flush=1. mem_stall cycles count only in cycle_cnt.
- rst has priority over every input; shadows and counters clear on the same edge, discarding in-flight hazards.

## Timing
- hazard, freeze, flush, bubble, id_issue combinational from current inputs and shadow state; zero latency.
- Shadow and counters update on rising edge; a counted event is visible the cycle after it occurs.
- RAW distance 1, FWD_EN=0: exactly 2 stall cycles (match in EXE, then MEM). Distance 2: 1 cycle. Distance ≥3: none.
- Load-use, FWD_EN=1: exactly 1 stall cycle.
- During rst=1 all outputs 0 except freeze/bubble/flush follow combinational rules on zeroed state (hazard=0).

## Test plan
- Reset: rst=1 two cycles -> all counters 0, hazard=0, freeze=0, flush=0; id_valid=1 gives id_issue=1.
- FWD_EN=0: issue dest=R1 wb_en=1, next ID src1=R1 -> hazard/freeze/bubble=1 for 2 cycles, id_issue on 3rd; stall_cnt=2.
- FWD_EN=1: load dest=R2, next ID src2=R2 src2_en=1 -> 1 stall cycle; same with non-load producer -> 0 stalls.
- Branch during hazard: hazard=1 and branch_taken=1 same cycle -> flush=1, bubble=1, freeze=0; flush_cnt=1, stall_cnt unchanged.
- mem_stall=1 for 3 cycles with R3 producer in EXE -> shadows held, freeze=1, cycle_cnt +3, stall_cnt +0; release -> remaining stall cycles resume.
- rst asserted mid-stall -> next cycle hazard=0, counters 0, pending ID instruction issues.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage core: RAW hazard detection against shadow EXE/MEM
// destinations, branch kill, memory-stall hold and saturating performance counters.
module pipe_hazard_ctrl #(
  parameter int REG_W  = 4,
  parameter bit FWD_EN = 1'b0,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_src1_en,
  input  logic             id_src2_en,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic [REG_W-1:0] id_dest,
  input  logic             branch_taken,
  input  logic             mem_stall,
  output logic             hazard,
  output logic             freeze,
  output logic             flush,
  output logic             bubble,
  output logic             id_issue,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             exe_valid_q, exe_valid_d;
  logic             exe_wb_en_q, exe_wb_en_d;
  logic             exe_mem_r_q, exe_mem_r_d;
  logic [REG_W-1:0] exe_dest_q, exe_dest_d;
  logic             mem_valid_q, mem_valid_d;
  logic             mem_wb_en_q, mem_wb_en_d;
  logic [REG_W-1:0] mem_dest_q, mem_dest_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic exe_vis_s, mem_vis_s, m_exe_s, m_mem_s, hazard_s;

  function automatic logic src_match(input logic [REG_W-1:0] dest);
    return (id_src1_en & (id_src1 == dest)) | (id_src2_en & (id_src2 == dest));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    logic [CNT_W-1:0] r;
    if (inc && (v != CNT_MAX)) begin
      r = v + CNT_ONE;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Hazard detection and stage-control priority; state reads as zero while in reset.
  always_comb begin
    exe_vis_s = exe_valid_q & ~rst;
    mem_vis_s = mem_valid_q & ~rst;
    m_exe_s   = src_match(exe_dest_q);
    m_mem_s   = src_match(mem_dest_q);
    if (FWD_EN) begin
      hazard_s = id_valid & exe_vis_s & exe_mem_r_q & m_exe_s;
    end else begin
      hazard_s = id_valid & ((exe_vis_s & exe_wb_en_q & m_exe_s) |
                             (mem_vis_s & mem_wb_en_q & m_mem_s));
    end
    hazard   = hazard_s;
    freeze   = 1'b0;
    flush    = 1'b0;
    bubble   = 1'b0;
    id_issue = 1'b0;
    if (mem_stall) begin
      freeze = 1'b1;
    end else if (branch_taken) begin
      flush  = 1'b1;
      bubble = 1'b1;
    end else if (hazard_s) begin
      freeze = 1'b1;
      bubble = 1'b1;
    end else begin
      id_issue = id_valid & ~rst;
    end
  end

  // Next-state for shadow stages and counters.
  always_comb begin
    exe_valid_d = exe_valid_q;
    exe_wb_en_d = exe_wb_en_q;
    exe_mem_r_d = exe_mem_r_q;
    exe_dest_d  = exe_dest_q;
    mem_valid_d = mem_valid_q;
    mem_wb_en_d = mem_wb_en_q;
    mem_dest_d  = mem_dest_q;
    if (!mem_stall) begin
      exe_valid_d = id_issue;
      exe_wb_en_d = id_issue & id_wb_en;
      exe_mem_r_d = id_issue & id_mem_r_en;
      exe_dest_d  = id_issue ? id_dest : {REG_W{1'b0}};
      mem_valid_d = exe_valid_q;
      mem_wb_en_d = exe_wb_en_q;
      mem_dest_d  = exe_dest_q;
    end else begin
      exe_valid_d = exe_valid_q;
    end
    cycle_cnt_d = sat_inc(cycle_cnt_q, 1'b1);
    stall_cnt_d = sat_inc(stall_cnt_q, hazard_s & ~branch_taken & ~mem_stall);
    flush_cnt_d = sat_inc(flush_cnt_q, flush);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_valid_q <= 1'b0;
      exe_wb_en_q <= 1'b0;
      exe_mem_r_q <= 1'b0;
      exe_dest_q  <= {REG_W{1'b0}};
      mem_valid_q <= 1'b0;
      mem_wb_en_q <= 1'b0;
      mem_dest_q  <= {REG_W{1'b0}};
      cycle_cnt_q <= {CNT_W{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      exe_valid_q <= exe_valid_d;
      exe_wb_en_q <= exe_wb_en_d;
      exe_mem_r_q <= exe_mem_r_d;
      exe_dest_q  <= exe_dest_d;
      mem_valid_q <= mem_valid_d;
      mem_wb_en_q <= mem_wb_en_d;
      mem_dest_q  <= mem_dest_d;
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a stall-everything instance and a forwarding
// instance with narrow counters share one stimulus stream.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst, id_valid, id_src1_en, id_src2_en, id_wb_en, id_mem_r_en;
  logic       branch_taken, mem_stall;
  logic [3:0] id_src1, id_src2, id_dest;

  logic        hz0, fz0, fl0, bb0, is0;
  logic        hz1, fz1, fl1, bb1, is1;
  logic [31:0] cyc0, stl0, fls0;
  logic [3:0]  cyc1, stl1, fls1;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(4), .FWD_EN(1'b0), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_en(id_src1_en), .id_src2_en(id_src2_en), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .branch_taken(branch_taken),
    .mem_stall(mem_stall), .hazard(hz0), .freeze(fz0), .flush(fl0), .bubble(bb0),
    .id_issue(is0), .cycle_cnt(cyc0), .stall_cnt(stl0), .flush_cnt(fls0));

  pipe_hazard_ctrl #(.REG_W(4), .FWD_EN(1'b1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_en(id_src1_en), .id_src2_en(id_src2_en), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .branch_taken(branch_taken),
    .mem_stall(mem_stall), .hazard(hz1), .freeze(fz1), .flush(fl1), .bubble(bb1),
    .id_issue(is1), .cycle_cnt(cyc1), .stall_cnt(stl1), .flush_cnt(fls1));

  // Expected control bits packed as {hazard, freeze, flush, bubble, id_issue}.
  typedef struct {
    logic       v;
    logic [3:0] s1;
    logic       s1e;
    logic [3:0] s2;
    logic       s2e;
    logic       wb;
    logic       mr;
    logic [3:0] d;
    logic       br;
    logic       ms;
    logic [4:0] e0;
    logic [4:0] e1;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic v, input logic [3:0] s1, input logic s1e,
                              input logic [3:0] s2, input logic s2e, input logic wb,
                              input logic mr, input logic [3:0] d, input logic br,
                              input logic ms, input logic [4:0] e0, input logic [4:0] e1);
    vec_t t;
    t.v = v; t.s1 = s1; t.s1e = s1e; t.s2 = s2; t.s2e = s2e; t.wb = wb;
    t.mr = mr; t.d = d; t.br = br; t.ms = ms; t.e0 = e0; t.e1 = e1;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.v; id_src1 = t.s1; id_src1_en = t.s1e; id_src2 = t.s2;
    id_src2_en = t.s2e; id_wb_en = t.wb; id_mem_r_en = t.mr; id_dest = t.d;
    branch_taken = t.br; mem_stall = t.ms;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] c_base, s_base;

  initial begin
    //            v    s1   e    s2   e    wb   mr   d    br   ms   dut0     dut1
    tbl[0]  = mk(1'b1,4'd0,1'b0,4'd0,1'b0,1'b1,1'b0,4'd1,1'b0,1'b0,5'b00001,5'b00001);
    tbl[1]  = mk(1'b1,4'd1,1'b1,4'd0,1'b0,1'b0,1'b0,4'd0,1'b0,1'b0,5'b11010,5'b00001);
    tbl[2]  = mk(1'b1,4'd1,1'b1,4'd0,1'b0,1'b0,1'b0,4'd0,1'b0,1'b0,5'b11010,5'b00001);
    tbl[3]  = mk(1'b1,4'd1,1'b1,4'd0,1'b0,1'b0,1'b0,4'd0,1'b0,1'b0,5'b00001,5'b00001);
    tbl[4]  = mk(1'b1,4'd0,1'b0,4'd0,1'b0,1'b1,1'b1,4'd2,1'b0,1'b0,5'b00001,5'b00001);
    tbl[5]  = mk(1'b1,4'd0,1'b0,4'd2,1'b1,1'b0,1'b0,4'd0,1'b0,1'b0,5'b11010,5'b11010);
    tbl[6]  = mk(1'b1,4'd0,1'b0,4'd2,1'b1,1'b0,1'b0,4'd0,1'b0,1'b0,5'b11010,5'b00001);
    tbl[7]  = mk(1'b1,4'd0,1'b0,4'd2,1'b1,1'b0,1'b0,4'd0,1'b0,1'b0,5'b00001,5'b00001);
    tbl[8]  = mk(1'b1,4'd0,1'b0,4'd0,1'b0,1'b1,1'b0,4'd3,1'b0,1'b0,5'b00001,5'b00001);
    tbl[9]  = mk(1'b1,4'd3,1'b0,4'd3,1'b0,1'b0,1'b0,4'd0,1'b0,1'b0,5'b00001,5'b00001);
    tbl[10] = mk(1'b0,4'd0,1'b0,4'd3,1'b1,1'b0,1'b0,4'd0,1'b0,1'b0,5'b00000,5'b00000);
    tbl[11] = mk(1'b1,4'd0,1'b0,4'd0,1'b0,1'b1,1'b0,4'd0,1'b0,1'b0,5'b00001,5'b00001);
    tbl[12] = mk(1'b1,4'd0,1'b1,4'd0,1'b0,1'b0,1'b0,4'd0,1'b0,1'b0,5'b11010,5'b00001);
    tbl[13] = mk(1'b1,4'd0,1'b1,4'd0,1'b0,1'b0,1'b0,4'd0,1'b1,1'b0,5'b10110,5'b00110);
    tbl[14] = mk(1'b1,4'd0,1'b0,4'd0,1'b0,1'b0,1'b0,4'd0,1'b1,1'b1,5'b01000,5'b01000);
    tbl[15] = mk(1'b1,4'd0,1'b0,4'd0,1'b0,1'b0,1'b0,4'd0,1'b0,1'b0,5'b00001,5'b00001);

    // Reset for two cycles with a live instruction in ID.
    rst = 1'b1;
    drive(mk(1'b1,4'd0,1'b1,4'd0,1'b0,1'b0,1'b0,4'd0,1'b0,1'b0,5'b00000,5'b00000));
    tick();
    tick();
    @(negedge clk);
    chk("rst_cycle_cnt", cyc0, 32'd0);
    chk("rst_stall_cnt", stl0, 32'd0);
    chk("rst_flush_cnt", fls0, 32'd0);
    chk("rst_ctrl", {27'd0, hz0, fz0, fl0, bb0, is0}, 32'd0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_dut0", i), {27'd0, hz0, fz0, fl0, bb0, is0}, {27'd0, tbl[i].e0});
      chk($sformatf("vec%0d_dut1", i), {27'd0, hz1, fz1, fl1, bb1, is1}, {27'd0, tbl[i].e1});
      tick();
    end

    chk("tbl_cycle0", cyc0, 32'd16);
    chk("tbl_stall0", stl0, 32'd5);
    chk("tbl_flush0", fls0, 32'd1);
    chk("tbl_cycle1_sat", {28'd0, cyc1}, 32'd15);
    chk("tbl_stall1", {28'd0, stl1}, 32'd1);
    chk("tbl_flush1", {28'd0, fls1}, 32'd1);

    // Memory stall over an R3 producer held in EXE, then the deferred RAW stalls.
    drive(mk(1'b1,4'd0,1'b0,4'd0,1'b0,1'b1,1'b0,4'd3,1'b0,1'b0,5'b0,5'b0));
    tick();
    c_base = cyc0;
    s_base = stl0;
    drive(mk(1'b1,4'd3,1'b1,4'd0,1'b0,1'b0,1'b0,4'd0,1'b0,1'b1,5'b0,5'b0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mstall%0d", i), {27'd0, hz0, fz0, fl0, bb0, is0}, {27'd0, 5'b11000});
      tick();
    end
    chk("mstall_cycle", cyc0, c_base + 32'd3);
    chk("mstall_stall", stl0, s_base);
    mem_stall = 1'b0;
    @(negedge clk);
    chk("resume0", {27'd0, hz0, fz0, fl0, bb0, is0}, {27'd0, 5'b11010});
    tick();
    @(negedge clk);
    chk("resume1", {27'd0, hz0, fz0, fl0, bb0, is0}, {27'd0, 5'b11010});
    tick();
    @(negedge clk);
    chk("resume2", {27'd0, hz0, fz0, fl0, bb0, is0}, {27'd0, 5'b00001});
    tick();
    chk("resume_stall", stl0, s_base + 32'd2);

    // Reset in the middle of a RAW stall discards the hazard.
    drive(mk(1'b1,4'd0,1'b0,4'd0,1'b0,1'b1,1'b0,4'd4,1'b0,1'b0,5'b0,5'b0));
    tick();
    drive(mk(1'b1,4'd4,1'b1,4'd0,1'b0,1'b0,1'b0,4'd0,1'b0,1'b0,5'b0,5'b0));
    @(negedge clk);
    chk("midrst_pre_hazard", {31'd0, hz0}, 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_rst", {30'd0, hz0, is0}, 32'd0);
    tick();
    rst = 1'b0;
    chk("midrst_cycle", cyc0, 32'd0);
    chk("midrst_stall", stl0, 32'd0);
    @(negedge clk);
    chk("midrst_issue", {27'd0, hz0, fz0, fl0, bb0, is0}, {27'd0, 5'b00001});
    tick();
    chk("midrst_cycle_after", cyc0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
